// File: rtl/mem_stage_pkg.sv
// Shared widths, status codes, instruction codes and M-register payload for the memory stage.
package mem_stage_pkg;

  localparam int unsigned DATA_WID  = 32;
  localparam int unsigned STAT_WID  = 3;
  localparam int unsigned ICODE_WID = 4;
  localparam int unsigned REG_WID   = 4;

  localparam logic [STAT_WID-1:0] SAOK = 3'd1;
  localparam logic [STAT_WID-1:0] SHLT = 3'd2;
  localparam logic [STAT_WID-1:0] SADR = 3'd3;
  localparam logic [STAT_WID-1:0] SINS = 3'd4;

  localparam logic [ICODE_WID-1:0] INOP   = 4'h1;
  localparam logic [ICODE_WID-1:0] IRMMOV = 4'h4;
  localparam logic [ICODE_WID-1:0] IMRMOV = 4'h5;
  localparam logic [ICODE_WID-1:0] ICALL  = 4'h8;
  localparam logic [ICODE_WID-1:0] IRET   = 4'h9;
  localparam logic [ICODE_WID-1:0] IPUSH  = 4'hA;
  localparam logic [ICODE_WID-1:0] IPOP   = 4'hB;

  localparam logic [REG_WID-1:0] RNONE = 4'hF;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } halt_state_e;

  typedef struct packed {
    logic [STAT_WID-1:0]  stat;
    logic [ICODE_WID-1:0] icode;
    logic [DATA_WID-1:0]  val_e;
    logic [DATA_WID-1:0]  val_a;
    logic [DATA_WID-1:0]  val_p;
    logic [REG_WID-1:0]   dst_e;
    logic [REG_WID-1:0]   dst_m;
  } m_reg_t;

  localparam m_reg_t M_BUBBLE = '{
    stat:  SAOK,
    icode: INOP,
    val_e: '0,
    val_a: '0,
    val_p: '0,
    dst_e: RNONE,
    dst_m: RNONE
  };

  function automatic logic is_store(input logic [ICODE_WID-1:0] icode);
    return (icode == IRMMOV) || (icode == ICALL) || (icode == IPUSH);
  endfunction

  function automatic logic is_load(input logic [ICODE_WID-1:0] icode);
    return (icode == IMRMOV) || (icode == IRET) || (icode == IPOP);
  endfunction

endpackage

// File: rtl/mem_stage_pipe_reg.sv
// M pipeline register: hold beats stall beats bubble beats load.
module mem_pipe_reg
  import mem_stage_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 hold,
  input  logic                 stall,
  input  logic                 bubble,
  input  logic [STAT_WID-1:0]  e_stat,
  input  logic [ICODE_WID-1:0] e_icode,
  input  logic [DATA_WID-1:0]  e_valE,
  input  logic [DATA_WID-1:0]  e_valA,
  input  logic [DATA_WID-1:0]  e_valP,
  input  logic [REG_WID-1:0]   e_dstE,
  input  logic [REG_WID-1:0]   e_dstM,
  output logic [STAT_WID-1:0]  M_stat,
  output logic [ICODE_WID-1:0] M_icode,
  output logic [DATA_WID-1:0]  M_valE,
  output logic [DATA_WID-1:0]  M_valA,
  output logic [DATA_WID-1:0]  M_valP,
  output logic [REG_WID-1:0]   M_dstE,
  output logic [REG_WID-1:0]   M_dstM
);

  m_reg_t m_q;
  m_reg_t m_d;

  // Incoming instruction from execute, packed for a single register update.
  always_comb begin
    m_d       = M_BUBBLE;
    m_d.stat  = e_stat;
    m_d.icode = e_icode;
    m_d.val_e = e_valE;
    m_d.val_a = e_valA;
    m_d.val_p = e_valP;
    m_d.dst_e = e_dstE;
    m_d.dst_m = e_dstM;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_q <= M_BUBBLE;
    end else if (hold || stall) begin
      m_q <= m_q;
    end else if (bubble) begin
      m_q <= M_BUBBLE;
    end else begin
      m_q <= m_d;
    end
  end

  assign M_stat  = m_q.stat;
  assign M_icode = m_q.icode;
  assign M_valE  = m_q.val_e;
  assign M_valA  = m_q.val_a;
  assign M_valP  = m_q.val_p;
  assign M_dstE  = m_q.dst_e;
  assign M_dstM  = m_q.dst_m;

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: M register, data-memory decode, write-back merge and sticky halt.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [STAT_WID-1:0]  e_stat,
  input  logic [ICODE_WID-1:0] e_icode,
  input  logic [DATA_WID-1:0]  e_valE,
  input  logic [DATA_WID-1:0]  e_valA,
  input  logic [DATA_WID-1:0]  e_valP,
  input  logic [REG_WID-1:0]   e_dstE,
  input  logic [REG_WID-1:0]   e_dstM,
  input  logic                 M_stall,
  input  logic                 M_bubble,
  output logic [DATA_WID-1:0]  mem_addr,
  output logic [DATA_WID-1:0]  mem_wdata,
  output logic                 mem_write,
  output logic                 mem_read,
  input  logic [DATA_WID-1:0]  mem_valM,
  input  logic                 dmem_error,
  output logic [STAT_WID-1:0]  m_stat,
  output logic [ICODE_WID-1:0] m_icode,
  output logic [DATA_WID-1:0]  m_valE,
  output logic [DATA_WID-1:0]  m_valM,
  output logic [REG_WID-1:0]   m_dstE,
  output logic [REG_WID-1:0]   m_dstM,
  output logic                 halted
);

  logic [STAT_WID-1:0]  M_stat;
  logic [ICODE_WID-1:0] M_icode;
  logic [DATA_WID-1:0]  M_valE;
  logic [DATA_WID-1:0]  M_valA;
  logic [DATA_WID-1:0]  M_valP;
  logic [REG_WID-1:0]   M_dstE;
  logic [REG_WID-1:0]   M_dstM;

  halt_state_e state;
  halt_state_e state_next;

  logic wr_raw;
  logic rd_raw;
  logic mem_ok;
  logic hold;

  // The register also freezes on the edge that enters HALTED, so the faulting
  // instruction stays visible on m_* for the rest of the halt.
  assign hold = halted || (m_stat != SAOK);

  mem_pipe_reg u_pipe_reg (
    .CLK     (CLK),
    .RST     (RST),
    .hold    (hold),
    .stall   (M_stall),
    .bubble  (M_bubble),
    .e_stat  (e_stat),
    .e_icode (e_icode),
    .e_valE  (e_valE),
    .e_valA  (e_valA),
    .e_valP  (e_valP),
    .e_dstE  (e_dstE),
    .e_dstM  (e_dstM),
    .M_stat  (M_stat),
    .M_icode (M_icode),
    .M_valE  (M_valE),
    .M_valA  (M_valA),
    .M_valP  (M_valP),
    .M_dstE  (M_dstE),
    .M_dstM  (M_dstM)
  );

  // Address and write-data selection from the latched instruction.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (M_icode)
      IRMMOV, IPUSH: begin
        mem_addr  = M_valE;
        mem_wdata = M_valA;
      end
      ICALL: begin
        mem_addr  = M_valE;
        mem_wdata = M_valP;
      end
      IMRMOV:     mem_addr = M_valE;
      IRET, IPOP: mem_addr = M_valA;
      default: begin
        mem_addr  = '0;
        mem_wdata = '0;
      end
    endcase
  end

  assign wr_raw = is_store(M_icode);
  assign rd_raw = is_load(M_icode);
  assign mem_ok = (M_stat == SAOK) && !halted;

  // An out-of-range store is dropped in the same cycle it is flagged.
  assign mem_write = wr_raw && mem_ok && !dmem_error;
  assign mem_read  = rd_raw && mem_ok;

  assign m_stat  = (dmem_error && (wr_raw || rd_raw)) ? SADR : M_stat;
  assign m_valM  = mem_read ? mem_valM : '0;
  assign m_icode = M_icode;
  assign m_valE  = M_valE;
  assign m_dstE  = M_dstE;
  assign m_dstM  = M_dstM;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_RUN:    if (m_stat != SAOK) state_next = ST_HALTED;
      ST_HALTED: state_next = ST_HALTED;
      default:   state_next = ST_RUN;
    endcase
  end

  always_comb begin
    halted = 1'b0;
    if (state == ST_HALTED) halted = 1'b1;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomised check of mem_stage against a cycle-level behavioural model with its own data memory.
module tb_mem_stage;

  localparam int unsigned DW      = 32;
  localparam int unsigned MEM_LEN = 16;

  logic          CLK;
  logic          RST;
  logic [2:0]    e_stat;
  logic [3:0]    e_icode;
  logic [DW-1:0] e_valE;
  logic [DW-1:0] e_valA;
  logic [DW-1:0] e_valP;
  logic [3:0]    e_dstE;
  logic [3:0]    e_dstM;
  logic          M_stall;
  logic          M_bubble;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_write;
  logic          mem_read;
  logic [DW-1:0] mem_valM;
  logic          dmem_error;
  logic [2:0]    m_stat;
  logic [3:0]    m_icode;
  logic [DW-1:0] m_valE;
  logic [DW-1:0] m_valM;
  logic [3:0]    m_dstE;
  logic [3:0]    m_dstM;
  logic          halted;

  int checks = 0;
  int errors = 0;

  mem_stage dut (
    .CLK(CLK), .RST(RST),
    .e_stat(e_stat), .e_icode(e_icode), .e_valE(e_valE), .e_valA(e_valA),
    .e_valP(e_valP), .e_dstE(e_dstE), .e_dstM(e_dstM),
    .M_stall(M_stall), .M_bubble(M_bubble),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_read(mem_read),
    .mem_valM(mem_valM), .dmem_error(dmem_error),
    .m_stat(m_stat), .m_icode(m_icode), .m_valE(m_valE), .m_valM(m_valM),
    .m_dstE(m_dstE), .m_dstM(m_dstM), .halted(halted)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Small data memory attached to the DUT; out-of-range addresses raise dmem_error.
  logic [DW-1:0] dmem [MEM_LEN];
  always_comb begin
    dmem_error = (mem_addr >= DW'(MEM_LEN));
    mem_valM   = dmem_error ? '0 : dmem[mem_addr[3:0]];
  end
  always @(posedge CLK) begin
    if (mem_write && mem_addr < DW'(MEM_LEN)) dmem[mem_addr[3:0]] <= mem_wdata;
  end

  // Reference model state: one instruction slot, halt flag and expected memory image.
  int unsigned r_stat, r_icode, r_dstE, r_dstM;
  longint unsigned r_valE, r_valA, r_valP;
  bit r_halt;
  longint unsigned r_mem [MEM_LEN];

  task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    r_stat = 1; r_icode = 1; r_valE = 0; r_valA = 0; r_valP = 0;
    r_dstE = 15; r_dstM = 15; r_halt = 0;
  endtask

  // Expected outputs for the instruction currently held by the model.
  task automatic model_outputs(output longint unsigned addr, output longint unsigned wdata,
                               output bit wr, output bit rd, output int unsigned stat,
                               output longint unsigned valm);
    bit is_wr, is_rd, err, ok;
    addr = 0; wdata = 0;
    case (r_icode)
      4, 10: begin addr = r_valE; wdata = r_valA; end
      8:     begin addr = r_valE; wdata = r_valP; end
      5:     addr = r_valE;
      9, 11: addr = r_valA;
      default: ;
    endcase
    is_wr = (r_icode == 4) || (r_icode == 8) || (r_icode == 10);
    is_rd = (r_icode == 5) || (r_icode == 9) || (r_icode == 11);
    err   = addr >= MEM_LEN;
    ok    = (r_stat == 1) && !r_halt;
    wr    = is_wr && ok && !err;
    rd    = is_rd && ok;
    stat  = (err && (is_wr || is_rd)) ? 3 : r_stat;
    valm  = (rd && !err) ? r_mem[addr] : 0;
  endtask

  // Drive one instruction, check current outputs, then advance model and DUT by one edge.
  task automatic run_cycle(input int unsigned st, input int unsigned ic, input longint unsigned ve,
                           input longint unsigned va, input longint unsigned vp,
                           input int unsigned de, input int unsigned dm,
                           input bit stall, input bit bubble);
    longint unsigned addr, wdata, valm;
    bit wr, rd;
    int unsigned stat;
    e_stat = 3'(st); e_icode = 4'(ic); e_valE = DW'(ve); e_valA = DW'(va); e_valP = DW'(vp);
    e_dstE = 4'(de); e_dstM = 4'(dm); M_stall = stall; M_bubble = bubble;
    #1;
    model_outputs(addr, wdata, wr, rd, stat, valm);
    chk("mem_addr", mem_addr, addr);
    chk("mem_wdata", mem_wdata, wdata);
    chk("mem_write", mem_write, wr);
    chk("mem_read", mem_read, rd);
    chk("m_stat", m_stat, stat);
    chk("m_valM", m_valM, valm);
    chk("m_icode", m_icode, r_icode);
    chk("m_valE", m_valE, r_valE);
    chk("m_dstE", m_dstE, r_dstE);
    chk("m_dstM", m_dstM, r_dstM);
    chk("halted", halted, r_halt);
    @(posedge CLK);
    if (wr) r_mem[addr] = wdata;
    if (r_halt || stat != 1) begin
      r_halt = 1;
    end else if (stall) begin
      r_halt = 0;
    end else if (bubble) begin
      model_reset();
    end else begin
      r_stat = st; r_icode = ic; r_valE = ve; r_valA = va; r_valP = vp;
      r_dstE = de; r_dstM = dm;
    end
    @(negedge CLK);
  endtask

  // Asynchronous reset pulse in the middle of the low phase.
  task automatic pulse_reset();
    #2 RST = 1'b1;
    #1;
    chk("rst_icode", m_icode, 1);
    chk("rst_dstE", m_dstE, 15);
    chk("rst_dstM", m_dstM, 15);
    chk("rst_halted", halted, 0);
    chk("rst_write", mem_write, 0);
    chk("rst_read", mem_read, 0);
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
  endtask

  function automatic int unsigned rand_icode();
    int unsigned pick = $urandom_range(0, 9);
    case (pick)
      0: return 4;  1: return 5;  2: return 8;  3: return 9;
      4: return 10; 5: return 11; 6: return 1;  7: return 6;
      8: return $urandom_range(0, 15);
      default: return 4;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < MEM_LEN; i++) begin
      dmem[i]  = DW'(i * 3 + 7);
      r_mem[i] = i * 3 + 7;
    end
    RST = 1'b0;
    e_stat = 3'd1; e_icode = 4'd1; e_valE = '0; e_valA = '0; e_valP = '0;
    e_dstE = 4'hF; e_dstM = 4'hF; M_stall = 1'b0; M_bubble = 1'b0;
    model_reset();
    @(negedge CLK);
    pulse_reset();

    // rmmov then mrmov to the same address.
    run_cycle(1, 4, 3, 'h55, 'h10, 15, 15, 0, 0);
    chk("rmmov_addr", mem_addr, 3);
    chk("rmmov_wdata", mem_wdata, 'h55);
    chk("rmmov_write", mem_write, 1);
    run_cycle(1, 5, 3, 0, 'h12, 15, 2, 0, 0);
    chk("mrmov_valM", m_valM, 'h55);

    // call pushes valP, ret reads it back.
    run_cycle(1, 8, 2, 0, 'h20, 4, 15, 0, 0);
    chk("call_wdata", mem_wdata, 'h20);
    run_cycle(1, 9, 6, 2, 'h21, 4, 15, 0, 0);
    chk("ret_read", mem_read, 1);
    chk("ret_addr", mem_addr, 2);
    chk("ret_valM", m_valM, 'h20);

    // Stall outranks bubble, then bubble alone inserts a nop.
    run_cycle(1, 4, 7, 'h99, 0, 1, 15, 1, 1);
    chk("stall_icode", m_icode, 9);
    run_cycle(1, 4, 7, 'h99, 0, 1, 15, 0, 1);
    chk("bubble_icode", m_icode, 1);
    chk("bubble_write", mem_write, 0);
    chk("bubble_read", mem_read, 0);

    // Out-of-range store faults, halts and freezes the stage.
    run_cycle(1, 4, 20, 'hAB, 0, 15, 15, 0, 0);
    chk("adr_stat", m_stat, 3);
    chk("adr_write", mem_write, 0);
    chk("adr_halted_early", halted, 0);
    run_cycle(1, 4, 5, 'h77, 0, 15, 15, 0, 0);
    chk("adr_halted", halted, 1);
    run_cycle(1, 4, 5, 'h77, 0, 15, 15, 0, 0);
    chk("frozen_icode", m_icode, 4);
    chk("frozen_valE", m_valE, 20);
    chk("frozen_write", mem_write, 0);
    run_cycle(1, 1, 0, 0, 0, 15, 15, 0, 0);
    chk("no_store_mem5", dmem[5], r_mem[5]);
    pulse_reset();

    // HLT status halts, reset resumes normal flow.
    run_cycle(2, 0, 0, 0, 0, 15, 15, 0, 0);
    chk("hlt_stat", m_stat, 2);
    run_cycle(1, 4, 1, 'h33, 0, 15, 15, 0, 0);
    chk("hlt_halted", halted, 1);
    pulse_reset();
    run_cycle(1, 4, 1, 'h33, 0, 15, 15, 0, 0);
    chk("resume_write", mem_write, 1);
    run_cycle(1, 1, 0, 0, 0, 15, 15, 0, 0);

    // Randomised traffic with occasional faults and reset pulses.
    for (int n = 0; n < 600; n++) begin
      int unsigned st = ($urandom_range(0, 39) == 0) ? $urandom_range(2, 4) : 1;
      run_cycle(st, rand_icode(),
                ($urandom_range(0, 15) == 0) ? $urandom_range(16, 40) : $urandom_range(0, 15),
                ($urandom_range(0, 15) == 0) ? 64'($urandom) : $urandom_range(0, 15),
                64'($urandom), $urandom_range(0, 15), $urandom_range(0, 15),
                $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      if (r_halt && $urandom_range(0, 3) == 0) pulse_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
